// File: rtl/mips_pkg.sv
// Shared encodings for the store unit: access sizes, FSM states and the size-to-lane mask.
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BEAT1 = 2'b01,
        S_BEAT2 = 2'b10
    } state_e;

    // Unshifted byte-lane mask for an access size; an illegal size enables no lanes.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_unit_if.sv
// Store request side and memory write side of the store unit, bundled as one interface.
interface mem_store_unit_if #(
    parameter int ASIZE = 31,
    parameter int DSIZE = 31
);
    logic             st_valid;
    logic             st_ready;
    logic [ASIZE:0]   st_addr;
    logic [DSIZE:0]   st_data;
    logic [1:0]       st_size;
    logic             st_done;
    logic             st_err;
    logic             mem_req;
    logic [ASIZE:0]   mem_addr;
    logic [DSIZE:0]   mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;

    // master: pipeline plus memory model; slave: the store unit
    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_lane_align.sv
// Positions store data on byte lanes: data shifted by the address offset across two words,
// and the matching 8-bit lane mask (upper nibble = lanes spilling into the next word).
module store_lane_align
    import mips_pkg::*;
#(
    parameter int DSIZE = 31
) (
    input  logic [DSIZE:0]     data_i,
    input  logic [1:0]         size_i,
    input  logic [1:0]         off_i,
    output logic [2*DSIZE+1:0] shifted_o,
    output logic [7:0]         lane_o
);

    always_comb begin
        shifted_o = {{(DSIZE+1){1'b0}}, data_i} << {off_i, 3'b000};
        lane_o    = {4'b0000, size_mask(size_i)} << off_i;
    end

endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: turns a pipeline store into one or two lane-positioned word writes.
// Define STORE_SPLIT_EN to split misaligned stores into two beats; otherwise they are rejected.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_IDLE  | ready for a store; illegal/rejected stores pulse st_err here
//  S_BEAT1 | first (or only) word write held on the memory bus until ack
//  S_BEAT2 | spill word at address+4 (only with STORE_SPLIT_EN)
module mem_store_unit
    import mips_pkg::*;
#(
    parameter int ASIZE = 31,
    parameter int DSIZE = 31
) (
    input logic             clk,
    input logic             rst_n,
    mem_store_unit_if.slave bus
);

    state_e             state_q;
    logic               mem_req_q;
    logic               done_q;
    logic               err_q;
    logic [ASIZE:0]     mem_addr_q;
    logic [DSIZE:0]     mem_wdata_q;
    logic [3:0]         mem_be_q;

    logic [1:0]         off_d;
    logic [2*DSIZE+1:0] shifted_d;
    logic [7:0]         lane_d;
    logic [DSIZE:0]     wdata_lo_d;
    logic               reject_d;

    assign off_d = bus.st_addr[1:0];

    store_lane_align #(.DSIZE(DSIZE)) u_align (
        .data_i    (bus.st_data),
        .size_i    (bus.st_size),
        .off_i     (off_d),
        .shifted_o (shifted_d),
        .lane_o    (lane_d)
    );

    // Bytes and even-offset halfwords are replicated so every lane carries the value.
    always_comb begin
        wdata_lo_d = shifted_d[DSIZE:0];
        if (bus.st_size == SZ_BYTE) begin
            wdata_lo_d = {4{bus.st_data[7:0]}};
        end else if ((bus.st_size == SZ_HALF) && !off_d[0]) begin
            wdata_lo_d = {2{bus.st_data[15:0]}};
        end
    end

`ifdef STORE_SPLIT_EN
    logic [DSIZE:0] hi_wdata_q;
    logic [3:0]     hi_be_q;

    assign reject_d = (bus.st_size == SZ_ILL);
`else
    logic unused_hi;

    assign reject_d  = (bus.st_size == SZ_ILL) || (lane_d[7:4] != 4'b0000);
    assign unused_hi = ^shifted_d[2*DSIZE+1:DSIZE+1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
`ifdef STORE_SPLIT_EN
            hi_wdata_q  <= '0;
            hi_be_q     <= 4'b0000;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.st_valid) begin
                        if (reject_d) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= S_BEAT1;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {bus.st_addr[ASIZE:2], 2'b00};
                            mem_wdata_q <= wdata_lo_d;
                            mem_be_q    <= lane_d[3:0];
`ifdef STORE_SPLIT_EN
                            hi_wdata_q  <= shifted_d[2*DSIZE+1:DSIZE+1];
                            hi_be_q     <= lane_d[7:4];
`endif
                        end
                    end
                end
                S_BEAT1: begin
                    if (bus.mem_ack) begin
`ifdef STORE_SPLIT_EN
                        if (hi_be_q != 4'b0000) begin
                            state_q     <= S_BEAT2;
                            mem_addr_q  <= mem_addr_q + (ASIZE+1)'(4);
                            mem_wdata_q <= hi_wdata_q;
                            mem_be_q    <= hi_be_q;
                        end else
`endif
                        begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
`ifdef STORE_SPLIT_EN
                S_BEAT2: begin
                    if (bus.mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.st_ready  = (state_q == S_IDLE);
    assign bus.st_done   = done_q;
    assign bus.st_err    = err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed vector table, random stores against a
// byte-lane reference model, plus reset-abort and back-to-back sequences.
module tb_mem_store_unit;

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          ack_wait;
        bit          err;
        int          beats;
        logic [31:0] a1;
        logic [31:0] w1;
        logic [3:0]  b1;
        logic [31:0] a2;
        logic [31:0] w2;
        logic [3:0]  b2;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mem_store_unit_if #(.ASIZE(31), .DSIZE(31)) bus ();

    mem_store_unit #(.ASIZE(31), .DSIZE(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.st_done === 1'b1 && bus.st_err === 1'b1) begin
                errors++;
                $display("FAIL done_err_exclusive: got done=1 err=1 expected not both");
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input int wt, input bit err,
                                input int beats, input logic [31:0] a1, input logic [31:0] w1,
                                input logic [3:0] b1, input logic [31:0] a2,
                                input logic [31:0] w2, input logic [3:0] b2);
        vec_t v;
        v.addr = addr; v.data = data; v.size = size; v.ack_wait = wt;
        v.err = err; v.beats = beats;
        v.a1 = a1; v.w1 = w1; v.b1 = b1;
        v.a2 = a2; v.w2 = w2; v.b2 = b2;
        return v;
    endfunction

    // Reference: place each stored byte on lane (offset + i); lanes past 3 spill to the next word.
    function automatic vec_t model(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [1:0] size, input int wt);
        vec_t v;
        int   off;
        int   nbytes;
        int   lane;
        off    = int'(addr[1:0]);
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        v.addr = addr; v.data = data; v.size = size; v.ack_wait = wt;
        v.a1 = addr & 32'hFFFF_FFFC;
        v.a2 = v.a1 + 32'd4;
        v.w1 = '0; v.w2 = '0; v.b1 = '0; v.b2 = '0;
        for (int i = 0; i < nbytes; i++) begin
            lane = off + i;
            if (lane < 4) begin
                v.b1[lane] = 1'b1;
                v.w1[8*lane +: 8] = data[8*i +: 8];
            end else begin
                v.b2[lane-4] = 1'b1;
                v.w2[8*(lane-4) +: 8] = data[8*i +: 8];
            end
        end
        v.err   = (nbytes == 0) || ((v.b2 != 4'b0000) && !SPLIT);
        v.beats = (v.b2 != 4'b0000) ? 2 : 1;
        return v;
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Entered and left just after a rising edge with the unit idle.
    task automatic apply(input vec_t v, input bit mask_wd, input string nm);
        logic [31:0] a, d, ea, ew, m;
        logic [3:0]  b, eb;
        bit          stable;
        chk({nm, ".ready"}, {31'd0, bus.st_ready}, 32'd1);
        bus.st_valid = 1'b1;
        bus.st_addr  = v.addr;
        bus.st_data  = v.data;
        bus.st_size  = v.size;
        @(posedge clk); #1;
        bus.st_valid = 1'b0;
        if (v.err) begin
            chk({nm, ".err"}, {31'd0, bus.st_err}, 32'd1);
            chk({nm, ".err_noreq"}, {31'd0, bus.mem_req}, 32'd0);
            @(posedge clk); #1;
            chk({nm, ".err_pulse"}, {31'd0, bus.st_err}, 32'd0);
            chk({nm, ".err_noreq2"}, {31'd0, bus.mem_req}, 32'd0);
            return;
        end
        chk({nm, ".noerr"}, {31'd0, bus.st_err}, 32'd0);
        for (int k = 0; k < v.beats; k++) begin
            if (k == 0) begin ea = v.a1; ew = v.w1; eb = v.b1; end
            else        begin ea = v.a2; ew = v.w2; eb = v.b2; end
            m = mask_wd ? lane_bits(eb) : 32'hFFFF_FFFF;
            a = bus.mem_addr; d = bus.mem_wdata; b = bus.mem_be;
            chk($sformatf("%s.req%0d", nm, k), {31'd0, bus.mem_req}, 32'd1);
            chk($sformatf("%s.addr%0d", nm, k), a, ea);
            chk($sformatf("%s.be%0d", nm, k), {28'd0, b}, {28'd0, eb});
            chk($sformatf("%s.wdata%0d", nm, k), d & m, ew & m);
            stable = 1'b1;
            for (int w = 0; w < v.ack_wait; w++) begin
                @(posedge clk); #1;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== a || bus.mem_wdata !== d ||
                    bus.mem_be !== b || bus.st_ready !== 1'b0 || bus.st_done !== 1'b0)
                    stable = 1'b0;
            end
            chk($sformatf("%s.stable%0d", nm, k), {31'd0, stable}, 32'd1);
            chk($sformatf("%s.busy%0d", nm, k), {31'd0, bus.st_ready}, 32'd0);
            bus.mem_ack = 1'b1;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (k < v.beats - 1) chk({nm, ".mid_done"}, {31'd0, bus.st_done}, 32'd0);
        end
        chk({nm, ".done"}, {31'd0, bus.st_done}, 32'd1);
        chk({nm, ".req_drop"}, {31'd0, bus.mem_req}, 32'd0);
        chk({nm, ".ready_back"}, {31'd0, bus.st_ready}, 32'd1);
        @(posedge clk); #1;
        chk({nm, ".done_pulse"}, {31'd0, bus.st_done}, 32'd0);
        chk({nm, ".idle_noreq"}, {31'd0, bus.mem_req}, 32'd0);
    endtask

    vec_t tbl[$];
    vec_t rv;
    bit   quiet;

    initial begin
        rst_n = 1'b1;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_size = '0;
        bus.mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst.mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst.st_done", {31'd0, bus.st_done}, 32'd0);
        chk("rst.st_err", {31'd0, bus.st_err}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.ready_after", {31'd0, bus.st_ready}, 32'd1);

        tbl.push_back(mk(32'h103, 32'hAABBCCDD, 2'b00, 0, 0, 1, 32'h100, 32'hDDDDDDDD, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(32'h202, 32'h00001234, 2'b01, 0, 0, 1, 32'h200, 32'h12341234, 4'b1100, 0, 0, 0));
        tbl.push_back(SPLIT ?
            mk(32'h301, 32'h11223344, 2'b10, 1, 0, 2, 32'h300, 32'h22334400, 4'b1110, 32'h304, 32'h00000011, 4'b0001) :
            mk(32'h301, 32'h11223344, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h400, 32'hCAFEF00D, 2'b10, 5, 0, 1, 32'h400, 32'hCAFEF00D, 4'b1111, 0, 0, 0));
        tbl.push_back(mk(32'h500, 32'h12345678, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(SPLIT ?
            mk(32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 0, 0, 2, 32'hFFFFFFFC, 32'hEF000000, 4'b1000, 32'h0, 32'h000000BE, 4'b0001) :
            mk(32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h000, 32'h12345655, 2'b00, 0, 0, 1, 32'h000, 32'h55555555, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(32'h006, 32'hABCD1234, 2'b01, 1, 0, 1, 32'h004, 32'h12341234, 4'b1100, 0, 0, 0));
        tbl.push_back(mk(32'h7FC, 32'h01020304, 2'b10, 2, 0, 1, 32'h7FC, 32'h01020304, 4'b1111, 0, 0, 0));
        tbl.push_back(SPLIT ?
            mk(32'h002, 32'h11223344, 2'b10, 0, 0, 2, 32'h000, 32'h33440000, 4'b1100, 32'h004, 32'h00001122, 4'b0011) :
            mk(32'h002, 32'h11223344, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Back-to-back: a new store is accepted in the same cycle st_done pulses.
        bus.st_valid = 1'b1; bus.st_addr = 32'h10; bus.st_data = 32'hA5A5F00F; bus.st_size = 2'b10;
        @(posedge clk); #1;
        bus.st_valid = 1'b0;
        chk("b2b.req1", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("b2b.done1", {31'd0, bus.st_done}, 32'd1);
        chk("b2b.ready", {31'd0, bus.st_ready}, 32'd1);
        bus.st_valid = 1'b1; bus.st_addr = 32'h21; bus.st_data = 32'h00000077; bus.st_size = 2'b00;
        @(posedge clk); #1;
        bus.st_valid = 1'b0;
        chk("b2b.done_clr", {31'd0, bus.st_done}, 32'd0);
        chk("b2b.req2", {31'd0, bus.mem_req}, 32'd1);
        chk("b2b.addr2", bus.mem_addr, 32'h20);
        chk("b2b.be2", {28'd0, bus.mem_be}, 32'h2);
        chk("b2b.wdata2", bus.mem_wdata, 32'h77777777);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("b2b.done2", {31'd0, bus.st_done}, 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a transaction abandons it without st_done.
        bus.st_valid = 1'b1;
        bus.st_addr  = SPLIT ? 32'h301 : 32'h400;
        bus.st_data  = 32'h11223344; bus.st_size = 2'b10;
        @(posedge clk); #1;
        bus.st_valid = 1'b0;
        chk("abort.req", {31'd0, bus.mem_req}, 32'd1);
        if (SPLIT) begin
            bus.mem_ack = 1'b1;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            chk("abort.beat2_addr", bus.mem_addr, 32'h304);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort.req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("abort.be_clr", {28'd0, bus.mem_be}, 32'd0);
        chk("abort.addr_clr", bus.mem_addr, 32'd0);
        #3 rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.st_done !== 1'b0 || bus.mem_req !== 1'b0 || bus.st_ready !== 1'b1) quiet = 1'b0;
        end
        chk("abort.no_done", {31'd0, quiet}, 32'd1);

        for (int n = 0; n < 200; n++) begin
            rv = model($urandom, $urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            apply(rv, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_store_unit.md
MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 Parameter ASIZE, default 31, MSB index of address buses (32-bit).
REQ-002 Parameter DSIZE, default 31, MSB index of data buses (32-bit).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 st_valid  input  1  pipeline presents a store.
REQ-006 st_ready  output  1  unit accepts a store this cycle.
REQ-007 st_addr  input  ASIZE+1  byte address of store.
REQ-008 st_data  input  DSIZE+1  register value, data in low bits.
REQ-009 st_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 st_done  output  1  one-cycle pulse, store fully written.
REQ-011 st_err  output  1  one-cycle pulse, store rejected, no write.
REQ-012 mem_req  output  1  memory write request, held until acknowledged.
REQ-013 mem_addr  output  ASIZE+1  word-aligned address, bits [1:0] always 0.
REQ-014 mem_wdata  output  DSIZE+1  lane-positioned write data.
REQ-015 mem_be  output  4  byte enables, bit n = lane n (little-endian).
REQ-016 mem_ack  input  1  memory accepted current beat.

Function
REQ-017 States SHALL be IDLE, BEAT1, BEAT2; st_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, st_valid&&st_ready SHALL capture addr, data, size into registers; illegal or (macro off) misaligned stores SHALL pulse st_err next cycle and remain IDLE; otherwise next state BEAT1.
REQ-019 Alignment offset off = st_addr[1:0]; mask = 0001/0011/1111 for byte/half/word; 64-bit shifted data = zero-extended data << (8*off); 8-bit lane mask = mask << off.
REQ-020 Byte store SHALL replicate: mem_wdata = {4{data[7:0]}}; halfword aligned SHALL replicate {2{data[15:0]}}; word = data; mem_be = lane mask[3:0].
REQ-021 A store is misaligned when lane mask[7:4] != 0 (half at off 3, word at off != 0).
REQ-022 In BEAT1/BEAT2 mem_req SHALL be 1 and mem_addr/mem_wdata/mem_be SHALL be stable until the cycle mem_ack=1.
REQ-023 BEAT1 on mem_ack: if lane mask[7:4]==0 go IDLE and pulse st_done next cycle; else go BEAT2.
REQ-024 BEAT2 SHALL drive mem_addr = {addr[ASIZE:2],2'b00}+4, mem_wdata = shifted[63:32], mem_be = lane mask[7:4]; on mem_ack go IDLE, pulse st_done.
REQ-025 Address increment SHALL wrap modulo 2^32 (0xFFFFFFFC+4 = 0x0).
REQ-026 mem_req SHALL drop the cycle after the final mem_ack; no back-to-back accept in the cycle st_done pulses is forbidden: st_ready returns 1 that same cycle.
REQ-027 st_done and st_err SHALL never be 1 in the same cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, st_ready=1 after release, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_done=0, st_err=0.
REQ-029 Reset during BEAT1/BEAT2 SHALL abandon the transaction without st_done; partial first beat is not rolled back.

Configuration
REQ-030 Macro STORE_SPLIT_EN defined: misaligned stores SHALL split into BEAT1+BEAT2 per REQ-023/024.
REQ-031 Macro STORE_SPLIT_EN undefined: misaligned stores SHALL pulse st_err, issue no mem_req; BEAT2 state logic SHALL not be synthesised.

Structure
REQ-032 Shared package mips_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and state encodings.
REQ-033 Combinational sub-module store_lane_align SHALL compute shifted data and 8-bit lane mask from data, size, offset.

Verification
REQ-034 sb addr 0x103, data 0xAABBCCDD, ack next cycle -> mem_addr 0x100, wdata 0xDDDDDDDD, be 1000, st_done once.
REQ-035 sh addr 0x202, data 0x1234 -> wdata 0x12341234, be 1100, single beat.
REQ-036 sw addr 0x301, data 0x11223344, split on -> beat1 0x300 wdata 0x22334400 be 1110; beat2 0x304 wdata 0x00000011 be 0001; split off -> st_err, no mem_req.
REQ-037 sw addr 0x400, ack withheld 5 cycles -> mem_req/addr/data/be stable 5 cycles, st_ready 0, st_done 1 cycle after ack.
REQ-038 st_size 11 -> st_err pulse, no mem_req; rst_n low during BEAT2 -> mem_req 0 immediately, no st_done.
REQ-039 sh addr 0xFFFFFFFF, split on -> beat2 mem_addr 0x00000000, be 0001.
